// File: rtl/sdf_stage_ctrl.sv
// sdf_stage_ctrl: sequencer for one radix-2 SDF FFT stage.
// Counts accepted samples, selects fill/bypass vs butterfly mode, generates
// the twiddle ROM address/enable and drains the feedback delay after the
// final input sample.
// Optional build macro: SDF_CTRL_ERR_EN enables the sticky protocol-error flag
// (misaligned in_last, in_last during PRIME). Without it o_err is tied to 0.
module sdf_stage_ctrl #(
    parameter int unsigned N      = 64,
    parameter int unsigned DELAY  = 32,
    parameter int unsigned ADDR_W = 5
) (
    input  logic              i_clk,
    input  logic              i_rst,
    input  logic              i_in_valid,
    input  logic              i_in_last,
    output logic              o_in_ready,
    output logic              o_bf_mode,
    output logic [ADDR_W-1:0] o_tw_addr,
    output logic              o_tw_en,
    output logic              o_out_valid,
    output logic              o_busy,
    output logic              o_frame_done,
    output logic              o_err
);

    localparam int unsigned CW     = $clog2(2 * DELAY);
    localparam int unsigned PH_BIT = $clog2(DELAY);
    localparam int unsigned STRIDE = N / (2 * DELAY);

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_PRIME = 2'd1,
        S_RUN   = 2'd2,
        S_FLUSH = 2'd3
    } state_t;

    state_t          r_state;
    state_t          w_state_nxt;
    logic [CW-1:0]   r_cnt;
    logic [CW-1:0]   r_fcnt;
    logic            w_in_ready;
    logic            w_xfer;
    logic            w_ph;
    logic            w_flush_end;
    logic [CW-1:0]   w_idx;
    logic [ADDR_W-1:0] w_tw;
    logic            w_tw_en;

    assign w_in_ready  = (r_state != S_FLUSH);
    assign w_xfer      = i_in_valid & w_in_ready;
    assign w_ph        = r_cnt[PH_BIT];
    assign w_flush_end = (r_state == S_FLUSH) && (r_fcnt == CW'(DELAY - 1));
    assign w_idx       = r_cnt & CW'(DELAY - 1);
    assign w_tw        = ADDR_W'(32'(w_idx) * STRIDE);

    // State register
    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    // Next-state decode; any accepted in_last heads to the drain
    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            S_IDLE: begin
                if (w_xfer) begin
                    w_state_nxt = i_in_last ? S_FLUSH : S_PRIME;
                end
            end
            S_PRIME: begin
                if (w_xfer) begin
                    if (i_in_last) begin
                        w_state_nxt = S_FLUSH;
                    end else if (w_ph) begin
                        w_state_nxt = S_RUN;
                    end
                end
            end
            S_RUN: begin
                if (w_xfer && i_in_last) begin
                    w_state_nxt = S_FLUSH;
                end
            end
            S_FLUSH: begin
                if (w_flush_end) begin
                    w_state_nxt = S_IDLE;
                end
            end
            default: w_state_nxt = S_IDLE;
        endcase
    end

    // Phase counter advances per transfer and per drain cycle; drain length counter
    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            r_cnt  <= '0;
            r_fcnt <= '0;
        end else if (w_flush_end) begin
            r_cnt  <= '0;
            r_fcnt <= '0;
        end else if (r_state == S_FLUSH) begin
            r_cnt  <= r_cnt + CW'(1);
            r_fcnt <= r_fcnt + CW'(1);
        end else if (w_xfer) begin
            r_cnt  <= r_cnt + CW'(1);
        end
    end

    // Output decode of state/phase, qualified by the current transfer
    always_comb begin
        o_in_ready   = w_in_ready;
        o_bf_mode    = 1'b0;
        o_out_valid  = 1'b0;
        o_frame_done = 1'b0;
        o_busy       = 1'b1;
        w_tw_en      = 1'b0;
        case (r_state)
            S_IDLE: begin
                o_busy    = 1'b0;
                o_bf_mode = w_ph;
            end
            S_PRIME: begin
                // The sample that completes priming is the first butterfly output
                o_bf_mode   = w_ph;
                o_out_valid = w_xfer & w_ph;
            end
            S_RUN: begin
                o_bf_mode   = w_ph;
                o_out_valid = w_xfer;
                w_tw_en     = w_xfer & ~w_ph;
            end
            S_FLUSH: begin
                o_out_valid  = 1'b1;
                w_tw_en      = 1'b1;
                o_frame_done = w_flush_end;
            end
            default: begin
                o_busy = 1'b0;
            end
        endcase
        o_tw_en   = w_tw_en;
        o_tw_addr = w_tw_en ? w_tw : '0;
    end

`ifdef SDF_CTRL_ERR_EN
    localparam logic [CW-1:0] CNT_MAX = CW'(2 * DELAY - 1);

    logic r_err;

    // Sticky error: stream ended anywhere other than the last phase slot
    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            r_err <= 1'b0;
        end else if (w_xfer && i_in_last && (r_cnt != CNT_MAX)) begin
            r_err <= 1'b1;
        end
    end

    assign o_err = r_err;
`else
    assign o_err = 1'b0;
`endif

endmodule

// File: tb/tb_sdf_stage_ctrl.sv
// Bench for sdf_stage_ctrl: two instances (DELAY=32 and DELAY=8, N=64).
// Drivers push expected output records into per-instance queues; a monitor
// pops and compares whenever an instance asserts o_out_valid.
module tb_sdf_stage_ctrl;

    typedef struct packed {
        logic       bf;
        logic       twen;
        logic [4:0] addr;
        logic       fd;
    } exp_t;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    int n_vec = 0;
    int n_err = 0;

    exp_t q0[$];
    exp_t q1[$];

    logic       rst   [2];
    logic       iv    [2];
    logic       il    [2];
    logic       rdy   [2];
    logic       bf    [2];
    logic [4:0] addr  [2];
    logic       twen  [2];
    logic       ov    [2];
    logic       busy  [2];
    logic       fd    [2];
    logic       err   [2];

`ifdef SDF_CTRL_ERR_EN
    localparam logic EXP_ERR = 1'b1;
`else
    localparam logic EXP_ERR = 1'b0;
`endif

    sdf_stage_ctrl #(.N(64), .DELAY(32), .ADDR_W(5)) u_d32 (
        .i_clk(clk), .i_rst(rst[0]), .i_in_valid(iv[0]), .i_in_last(il[0]),
        .o_in_ready(rdy[0]), .o_bf_mode(bf[0]), .o_tw_addr(addr[0]),
        .o_tw_en(twen[0]), .o_out_valid(ov[0]), .o_busy(busy[0]),
        .o_frame_done(fd[0]), .o_err(err[0])
    );

    sdf_stage_ctrl #(.N(64), .DELAY(8), .ADDR_W(5)) u_d8 (
        .i_clk(clk), .i_rst(rst[1]), .i_in_valid(iv[1]), .i_in_last(il[1]),
        .o_in_ready(rdy[1]), .o_bf_mode(bf[1]), .o_tw_addr(addr[1]),
        .o_tw_en(twen[1]), .o_out_valid(ov[1]), .o_busy(busy[1]),
        .o_frame_done(fd[1]), .o_err(err[1])
    );

    function automatic int dl(input int s);
        return (s == 0) ? 32 : 8;
    endfunction

    function automatic int qsize(input int s);
        return (s == 0) ? q0.size() : q1.size();
    endfunction

    function automatic void qpush(input int s, input exp_t e);
        if (s == 0) q0.push_back(e);
        else        q1.push_back(e);
    endfunction

    function automatic exp_t qpop(input int s);
        if (s == 0) return q0.pop_front();
        return q1.pop_front();
    endfunction

    // Expected output of sample k of a stream (k >= DELAY)
    function automatic exp_t samp_exp(input int s, input int k);
        exp_t e;
        int   d;
        int   c;
        d      = dl(s);
        c      = k % (2 * d);
        e.bf   = (c >= d);
        e.twen = (c < d);
        e.addr = (c < d) ? 5'((c % d) * (32 / d)) : 5'd0;
        e.fd   = 1'b0;
        return e;
    endfunction

    // Expected drain output j, drain starting at phase count c0
    function automatic exp_t flush_exp(input int s, input int c0, input int j);
        exp_t e;
        int   d;
        d      = dl(s);
        e.bf   = 1'b0;
        e.twen = 1'b1;
        e.addr = 5'(((c0 + j) % d) * (32 / d));
        e.fd   = (j == d - 1);
        return e;
    endfunction

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] req);
        n_vec++;
        if (act !== req) begin
            n_err++;
            $display("FAIL %s: got %0h required %0h at %0t", nm, act, req, $time);
        end
    endtask

    // Monitor: every presented output must match the head of its queue
    initial begin
        exp_t a;
        exp_t e;
        forever begin
            @(negedge clk);
            for (int s = 0; s < 2; s++) begin
                if (ov[s] === 1'b1) begin
                    a = {bf[s], twen[s], addr[s], fd[s]};
                    if (qsize(s) == 0) begin
                        n_vec++;
                        n_err++;
                        $display("FAIL unexpected_out[%0d]: got %h required none at %0t", s, a, $time);
                    end else begin
                        e = qpop(s);
                        chk($sformatf("out[%0d]", s), 32'(a), 32'(e));
                    end
                end
            end
        end
    end

    // Offer sample k; waits for acceptance, returns the number of stalled cycles
    task automatic send(input int s, input int k, input bit last, output int stalls);
        int  d;
        int  c0;
        bit  done;
        d = dl(s);
        if (k >= d) qpush(s, samp_exp(s, k));
        if (last) begin
            c0 = (k + 1) % (2 * d);
            for (int j = 0; j < d; j++) qpush(s, flush_exp(s, c0, j));
        end
        iv[s]  = 1'b1;
        il[s]  = last;
        stalls = 0;
        done   = 1'b0;
        while (!done) begin
            @(negedge clk);
            if (rdy[s] === 1'b1) begin
                done = 1'b1;
            end else begin
                stalls++;
                if (stalls > 200) begin
                    n_vec++;
                    n_err++;
                    $display("FAIL handshake_timeout[%0d]: got stalls %0d required <= 200", s, stalls);
                    done = 1'b1;
                end
            end
        end
        @(posedge clk);
        #1;
        iv[s] = 1'b0;
        il[s] = 1'b0;
    endtask

    // Upstream bubble: outputs must stay quiet
    task automatic gap(input int s, input int len);
        for (int i = 0; i < len; i++) begin
            @(negedge clk);
            chk("gap_out_valid", 32'(ov[s]), 32'd0);
            chk("gap_tw_en", 32'(twen[s]), 32'd0);
            chk("gap_frame_done", 32'(fd[s]), 32'd0);
            chk("gap_tw_addr", 32'(addr[s]), 32'd0);
            @(posedge clk);
            #1;
        end
    endtask

    task automatic stream(input int s, input int n, input int last_at,
                          input int gap_at, input int gap_len);
        int st;
        for (int k = 0; k < n; k++) begin
            if (k == gap_at) gap(s, gap_len);
            send(s, k, (k == last_at), st);
        end
    endtask

    task automatic wait_drain(input int s);
        int t;
        t = 0;
        while (qsize(s) != 0 && t < 300) begin
            @(posedge clk);
            t++;
        end
        chk("drain_queue_empty", 32'(qsize(s)), 32'd0);
        @(negedge clk);
        chk("idle_busy", 32'(busy[s]), 32'd0);
        chk("idle_in_ready", 32'(rdy[s]), 32'd1);
        chk("idle_out_valid", 32'(ov[s]), 32'd0);
        @(posedge clk);
        #1;
    endtask

    task automatic chk_reset(input int s);
        chk("rst_in_ready", 32'(rdy[s]), 32'd1);
        chk("rst_bf_mode", 32'(bf[s]), 32'd0);
        chk("rst_tw_addr", 32'(addr[s]), 32'd0);
        chk("rst_tw_en", 32'(twen[s]), 32'd0);
        chk("rst_out_valid", 32'(ov[s]), 32'd0);
        chk("rst_busy", 32'(busy[s]), 32'd0);
        chk("rst_frame_done", 32'(fd[s]), 32'd0);
        chk("rst_err", 32'(err[s]), 32'd0);
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        int st;
        for (int s = 0; s < 2; s++) begin
            rst[s] = 1'b1;
            iv[s]  = 1'b0;
            il[s]  = 1'b0;
        end
        repeat (2) @(posedge clk);
        #1;
        @(negedge clk);
        chk_reset(0);
        chk_reset(1);
        @(posedge clk);
        #1;
        rst[0] = 1'b0;
        rst[1] = 1'b0;

        // Contiguous aligned stream, DELAY=32
        stream(0, 64, 63, -1, 0);
        wait_drain(0);
        chk("err_aligned_d32", 32'(err[0]), 32'd0);

        // Contiguous aligned stream, DELAY=8
        stream(1, 64, 63, -1, 0);
        wait_drain(1);
        chk("err_aligned_d8", 32'(err[1]), 32'd0);

        // Five-cycle bubble before sample 40
        stream(0, 64, 63, 40, 5);
        wait_drain(0);

        // Upstream holds valid through the drain into a second stream
        for (int k = 0; k < 64; k++) send(0, k, (k == 63), st);
        send(0, 0, 1'b0, st);
        chk("b2b_stall_cycles", 32'(st), 32'd32);
        for (int k = 1; k < 64; k++) send(0, k, (k == 63), st);
        wait_drain(0);
        chk("err_b2b", 32'(err[0]), 32'd0);

        // Misaligned last on sample 50
        stream(0, 51, 50, -1, 0);
        wait_drain(0);
        chk("err_misaligned", 32'(err[0]), 32'(EXP_ERR));

        // Reset in the middle of a stream
        for (int k = 0; k < 45; k++) send(0, k, 1'b0, st);
        rst[0] = 1'b1;
        @(posedge clk);
        #1;
        rst[0] = 1'b0;
        @(negedge clk);
        chk_reset(0);
        repeat (40) @(posedge clk);
        #1;
        chk("rst_no_pending", 32'(qsize(0)), 32'd0);

        // Fresh stream after reset starts from phase 0
        stream(0, 64, 63, -1, 0);
        wait_drain(0);
        chk("err_after_rst", 32'(err[0]), 32'd0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
